// File: rtl/seq_det_pkg.sv
// seq_det_pkg
//   Shared constants for the serial pattern detector slice.
//   DEF_PAT_W   : default pattern length in bits
//   DEF_PAT_RST : default pattern loaded while reset is low
//   DEF_CNT_W   : default width of the match counter
//   state_w()   : bits needed to hold a state number 0..pat_w
package seq_det_pkg;

  localparam int          DEF_PAT_W   = 4;
  localparam logic [3:0]  DEF_PAT_RST = 4'b1011;
  localparam int          DEF_CNT_W   = 8;

  function automatic int state_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_match_len.sv
// seq_match_len
//   Combinational next-state search for the detector. Looks at the most
//   recent accepted bits plus the incoming bit and returns the longest
//   pattern prefix that they end with, limited by how many bits are
//   actually available since the history was last emptied.
//   hist     : previous PAT_W-1 accepted bits, bit 0 is the newest
//   fill     : number of bits accepted into the history (saturates at PAT_W)
//   pattern  : active pattern, pattern[PAT_W-1] is the first bit expected
//   d_in     : incoming bit being evaluated
//   next_len : matched prefix length after accepting d_in
module seq_match_len
  import seq_det_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W
) (
  input  logic [PAT_W-2:0]          hist,
  input  logic [state_w(PAT_W)-1:0] fill,
  input  logic [PAT_W-1:0]          pattern,
  input  logic                      d_in,
  output logic [state_w(PAT_W)-1:0] next_len
);

  localparam int SW = state_w(PAT_W);

  logic [PAT_W-1:0] window;
  int               avail;
  int               best;
  logic             ok;

  assign window = {hist, d_in};

  // Try every prefix length; the last one that fits wins, giving the
  // longest. For length k, window[k-1] (oldest of the k bits) must equal
  // the first pattern bit and window[0] the k-th pattern bit.
  always_comb begin
    avail = int'(fill) + 1;
    if (avail > PAT_W) avail = PAT_W;
    best = 0;
    ok   = 1'b0;
    for (int k = 1; k <= PAT_W; k++) begin
      ok = (k <= avail);
      for (int i = 0; i < k; i++) begin
        if (window[i] != pattern[PAT_W-k+i]) ok = 1'b0;
      end
      if (ok) best = k;
    end
    next_len = SW'(best);
  end

endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param
//   Moore serial pattern detector with loadable pattern, optional
//   overlapping matches and a saturating match counter.
//   clk       : rising-edge clock
//   reset     : asynchronous active-low reset
//   d_in      : serial data bit, taken only while d_valid=1
//   d_valid   : qualifies d_in
//   pattern   : new pattern, pattern[PAT_W-1] is the first bit expected
//   pat_load  : loads pattern and restarts detection (d_in ignored that edge)
//   cnt_clr   : synchronous clear of match_cnt, beats a same-edge match
//   state     : number of pattern-prefix bits currently matched
//   d_out     : high exactly while the whole pattern is matched
//   match_cnt : saturating count of matches
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(DEF_PAT_RST),
  parameter int               OVERLAP = 1,
  parameter int               CNT_W   = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      d_in,
  input  logic                      d_valid,
  input  logic [PAT_W-1:0]          pattern,
  input  logic                      pat_load,
  input  logic                      cnt_clr,
  output logic [state_w(PAT_W)-1:0] state,
  output logic                      d_out,
  output logic [CNT_W-1:0]          match_cnt
);

  localparam int               SW      = state_w(PAT_W);
  localparam logic [SW-1:0]    FULL    = SW'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SW-1:0]    state_q;
  logic [SW-1:0]    fill_q;
  logic [SW-1:0]    next_len;
  logic [PAT_W-2:0] hist_q;
  logic [PAT_W-1:0] pat_q;
  logic [PAT_W-1:0] window;
  logic             d_out_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             hit;

  // A load takes priority over data on the same edge.
  assign accept = d_valid && !pat_load;
  assign hit    = accept && (next_len == FULL);
  assign window = {hist_q, d_in};

  seq_match_len #(
    .PAT_W (PAT_W)
  ) u_match (
    .hist     (hist_q),
    .fill     (fill_q),
    .pattern  (pat_q),
    .d_in     (d_in),
    .next_len (next_len)
  );

  // All detector state lives here. d_out is registered from the next
  // state so it rises on the edge that takes the final pattern bit and
  // never follows d_in combinationally. In non-overlapping mode a full
  // match empties the history so the following bit starts from scratch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= '0;
      fill_q  <= '0;
      hist_q  <= '0;
      pat_q   <= PAT_RST;
      d_out_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (pat_load) begin
        pat_q   <= pattern;
        state_q <= '0;
        fill_q  <= '0;
        hist_q  <= '0;
        d_out_q <= 1'b0;
      end else if (d_valid) begin
        state_q <= next_len;
        d_out_q <= (next_len == FULL);
        if ((OVERLAP == 0) && (next_len == FULL)) begin
          fill_q <= '0;
          hist_q <= '0;
        end else begin
          fill_q <= (fill_q == FULL) ? FULL : fill_q + 1'b1;
          hist_q <= window[PAT_W-2:0];
        end
      end

      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (hit && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign state     = state_q;
  assign d_out     = d_out_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param
//   Drives three detectors from the same inputs: overlapping with an 8-bit
//   counter, non-overlapping with an 8-bit counter, and overlapping with a
//   2-bit counter. Expected values come from a prefix-search model over a
//   queue of accepted bits.
module tb_seq_detector_param;

  logic       clk;
  logic       reset;
  logic       d_in;
  logic       d_valid;
  logic [3:0] pattern;
  logic       pat_load;
  logic       cnt_clr;

  logic [2:0] state_ov, state_no, state_c2;
  logic       d_out_ov, d_out_no, d_out_c2;
  logic [7:0] cnt_ov, cnt_no;
  logic [1:0] cnt_c2;

  int compares;
  int errors;

  bit         q_ov[$];
  bit         q_no[$];
  logic [3:0] pat_m;
  int         st_ov, st_no;
  int         m_cnt_ov, m_cnt_no, m_cnt_c2;

  seq_detector_param #(.PAT_W(4), .PAT_RST(4'b1011), .OVERLAP(1), .CNT_W(8)) dut_ov (
    .clk(clk), .reset(reset), .d_in(d_in), .d_valid(d_valid), .pattern(pattern),
    .pat_load(pat_load), .cnt_clr(cnt_clr), .state(state_ov), .d_out(d_out_ov),
    .match_cnt(cnt_ov));

  seq_detector_param #(.PAT_W(4), .PAT_RST(4'b1011), .OVERLAP(0), .CNT_W(8)) dut_no (
    .clk(clk), .reset(reset), .d_in(d_in), .d_valid(d_valid), .pattern(pattern),
    .pat_load(pat_load), .cnt_clr(cnt_clr), .state(state_no), .d_out(d_out_no),
    .match_cnt(cnt_no));

  seq_detector_param #(.PAT_W(4), .PAT_RST(4'b1011), .OVERLAP(1), .CNT_W(2)) dut_c2 (
    .clk(clk), .reset(reset), .d_in(d_in), .d_valid(d_valid), .pattern(pattern),
    .pat_load(pat_load), .cnt_clr(cnt_clr), .state(state_c2), .d_out(d_out_c2),
    .match_cnt(cnt_c2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Longest k such that the last k accepted bits equal the first k
  // pattern bits.
  function automatic int longestPrefix(input bit hist[$], input logic [3:0] pat);
    int  n;
    int  lim;
    bit  same;
    n   = hist.size();
    lim = (n < 4) ? n : 4;
    for (int k = lim; k >= 1; k--) begin
      same = 1'b1;
      for (int i = 0; i < k; i++) begin
        if (hist[n-k+i] != pat[3-i]) same = 1'b0;
      end
      if (same) return k;
    end
    return 0;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compares++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkVal("state_ov", 32'(state_ov), 32'(st_ov));
    checkVal("d_out_ov", 32'(d_out_ov), 32'(st_ov == 4));
    checkVal("cnt_ov",   32'(cnt_ov),   32'(m_cnt_ov));
    checkVal("state_no", 32'(state_no), 32'(st_no));
    checkVal("d_out_no", 32'(d_out_no), 32'(st_no == 4));
    checkVal("cnt_no",   32'(cnt_no),   32'(m_cnt_no));
    checkVal("state_c2", 32'(state_c2), 32'(st_ov));
    checkVal("d_out_c2", 32'(d_out_c2), 32'(st_ov == 4));
    checkVal("cnt_c2",   32'(cnt_c2),   32'(m_cnt_c2));
  endtask

  task automatic modelReset();
    q_ov.delete();
    q_no.delete();
    pat_m    = 4'b1011;
    st_ov    = 0;
    st_no    = 0;
    m_cnt_ov = 0;
    m_cnt_no = 0;
    m_cnt_c2 = 0;
  endtask

  // One clock cycle: drive on the falling edge, update the model on the
  // rising edge, compare shortly after.
  task automatic applyStimulus(input bit dv, input bit d, input bit pl,
                               input logic [3:0] pv, input bit clr);
    @(negedge clk);
    d_valid  = dv;
    d_in     = d;
    pat_load = pl;
    pattern  = pv;
    cnt_clr  = clr;
    @(posedge clk);
    if (pl) begin
      pat_m = pv;
      q_ov.delete();
      q_no.delete();
      st_ov = 0;
      st_no = 0;
    end else if (dv) begin
      q_ov.push_back(d);
      if (q_ov.size() > 8) void'(q_ov.pop_front());
      st_ov = longestPrefix(q_ov, pat_m);
      if (st_ov == 4) begin
        if (m_cnt_ov < 255) m_cnt_ov++;
        if (m_cnt_c2 < 3)   m_cnt_c2++;
      end
      q_no.push_back(d);
      st_no = longestPrefix(q_no, pat_m);
      if (st_no == 4) begin
        if (m_cnt_no < 255) m_cnt_no++;
        q_no.delete();
      end
    end
    if (clr) begin
      m_cnt_ov = 0;
      m_cnt_no = 0;
      m_cnt_c2 = 0;
    end
    #1;
    checkOutput();
  endtask

  task automatic sendBit(input bit d);
    applyStimulus(1'b1, d, 1'b0, 4'b0000, 1'b0);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulseReset();
    #2;
    reset = 1'b0;
    #1;
    modelReset();
    checkOutput();
    reset = 1'b1;
  endtask

  initial begin
    compares = 0;
    errors   = 0;
    reset    = 1'b0;
    d_in     = 1'b0;
    d_valid  = 1'b0;
    pattern  = 4'b0000;
    pat_load = 1'b0;
    cnt_clr  = 1'b0;
    modelReset();

    $display("[TB] reset state");
    #12;
    checkOutput();
    reset = 1'b1;

    $display("[TB] 1011 from reset, then 011 for a second overlapping match");
    sendBit(1'b1);
    checkVal("first_bit_state", 32'(state_ov), 32'd1);
    sendBit(1'b0);
    checkVal("second_bit_state", 32'(state_ov), 32'd2);
    sendBit(1'b1);
    checkVal("third_bit_state", 32'(state_ov), 32'd3);
    sendBit(1'b1);
    checkVal("match_state", 32'(state_ov), 32'd4);
    checkVal("match_d_out", 32'(d_out_ov), 32'd1);
    checkVal("match_cnt", 32'(cnt_ov), 32'd1);
    sendBit(1'b0);
    sendBit(1'b1);
    sendBit(1'b1);
    checkVal("overlap_cnt", 32'(cnt_ov), 32'd2);
    checkVal("overlap_d_out", 32'(d_out_ov), 32'd1);
    checkVal("nonoverlap_cnt", 32'(cnt_no), 32'd1);
    checkVal("nonoverlap_d_out", 32'(d_out_no), 32'd0);

    $display("[TB] 1011 with gaps of invalid cycles");
    pulseReset();
    sendBit(1'b1); idleCycle(); idleCycle(); idleCycle();
    checkVal("gap_hold_state", 32'(state_ov), 32'd1);
    sendBit(1'b0); idleCycle(); idleCycle(); idleCycle();
    sendBit(1'b1); idleCycle(); idleCycle(); idleCycle();
    sendBit(1'b1);
    checkVal("gap_match_state", 32'(state_ov), 32'd4);
    idleCycle(); idleCycle();
    checkVal("gap_hold_d_out", 32'(d_out_ov), 32'd1);
    checkVal("gap_cnt", 32'(cnt_ov), 32'd1);

    $display("[TB] pattern load mid-sequence");
    pulseReset();
    sendBit(1'b1);
    sendBit(1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'b0110, 1'b0);
    checkVal("load_state", 32'(state_ov), 32'd0);
    sendBit(1'b0); sendBit(1'b1); sendBit(1'b1); sendBit(1'b0);
    checkVal("load_d_out", 32'(d_out_ov), 32'd1);
    checkVal("load_cnt", 32'(cnt_ov), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b1011, 1'b0);
    checkVal("load_keeps_cnt", 32'(cnt_ov), 32'd1);

    $display("[TB] 2-bit counter saturation and clear priority");
    pulseReset();
    sendBit(1'b1);
    for (int m = 0; m < 5; m++) begin
      sendBit(1'b0); sendBit(1'b1); sendBit(1'b1);
    end
    checkVal("sat_cnt_c2", 32'(cnt_c2), 32'd3);
    checkVal("sat_cnt_ov", 32'(cnt_ov), 32'd5);
    sendBit(1'b0);
    sendBit(1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
    checkVal("clr_wins_c2", 32'(cnt_c2), 32'd0);
    checkVal("clr_wins_ov", 32'(cnt_ov), 32'd0);

    $display("[TB] asynchronous reset mid-sequence");
    pulseReset();
    sendBit(1'b1); sendBit(1'b0); sendBit(1'b1);
    pulseReset();
    checkVal("async_rst_state", 32'(state_ov), 32'd0);
    sendBit(1'b1);
    checkVal("after_rst_state", 32'(state_ov), 32'd1);
    checkVal("after_rst_d_out", 32'(d_out_ov), 32'd0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 500; n++) begin
      applyStimulus($urandom_range(0, 3) != 0,
                    1'($urandom_range(0, 1)),
                    $urandom_range(0, 40) == 0,
                    4'($urandom_range(0, 15)),
                    $urandom_range(0, 60) == 0);
      if ($urandom_range(0, 150) == 0) pulseReset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
    $finish;
  end

endmodule
